id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst_n  in  1  reset, asynchronous and active-low.
REQ-003 in_valid  in  1  decode presents an instruction this cycle.
REQ-004 in_ready  out  1  stage accepts the instruction this cycle.
REQ-005 in_rs1_addr, in_rs2_addr, in_rd_addr  in  5 each  source and destination register indices.
REQ-006 in_rs1_data, in_rs2_data, in_imm  in  32 each  register-file read data and sign-extended immediate.
REQ-007 in_alu_control  in  4  ALU operation code, passed through unchanged.
REQ-008 in_alu_src, in_reg_write, in_mem_read, in_mem_write  in  1 each  B=imm select and control flags.
REQ-009 flush  in  1  discard the held instruction (branch redirect).
REQ-010 exmem_reg_write, exmem_mem_read  in  1 each; exmem_rd  in  5; exmem_result  in  32  EX/MEM forwarding source.
REQ-011 memwb_reg_write  in  1; memwb_rd  in  5; memwb_result  in  32  MEM/WB forwarding and write-back source.
REQ-012 out_valid  out  1  ALU operands are valid and hazard-free.
REQ-013 out_ready  in  1  downstream consumes the instruction this cycle.
REQ-014 alu_a, alu_b  out  32 each  forwarded ALU operands.
REQ-015 alu_control  out  4; out_rd  out  5; out_reg_write, out_mem_read, out_mem_write  out  1 each  held controls.
REQ-016 store_data  out  32  forwarded rs2 value, for stores.

Function
REQ-017 State: one valid bit plus registered copies of all in_* fields.
REQ-018 Define hazard = valid & exmem_mem_read & exmem_reg_write & exmem_rd!=0 & (exmem_rd==rs1_addr | (exmem_rd==rs2_addr & (!alu_src | mem_write))).
REQ-019 out_valid = valid & !hazard & !flush; fire = out_valid & out_ready.
REQ-020 in_ready = !valid | fire; combinational, with no path from in_valid.
REQ-021 Capture on in_valid & in_ready: all fields are loaded and valid=1 on the next edge.
REQ-022 fire without capture: valid=0 next edge.
REQ-023 flush: valid=0 next edge; takes priority over capture and hold; in_ready is still computed per REQ-020.
REQ-024 Forwarding per source (rs1, rs2), combinational: rs==0 gives the held data; else exmem match (reg_write & rd==rs & !mem_read) gives exmem_result; else memwb match (reg_write & rd==rs) gives memwb_result; else the held data.
REQ-025 EX/MEM match has priority over MEM/WB match; x0 is never forwarded.
REQ-026 alu_a = forwarded rs1; store_data = forwarded rs2; alu_b = alu_src ? imm : forwarded rs2.
REQ-027 Write-back snoop: while valid and not firing, a MEM/WB match on rs1 or rs2 overwrites that held data with memwb_result at the edge, so stalls never lose a retiring value.
REQ-028 A stall of any length (out_ready=0 or hazard) holds all outputs except snoop-updated operands.
REQ-029 Back-to-back: fire and capture in the same cycle yields the new instruction next cycle with no bubble.
REQ-030 alu_control passes through bit-exact; no decode or legality check.

Reset
REQ-031 rst_n low: valid=0 immediately, without waiting for a clock; all held fields=0; out_valid=0 and in_ready=1 while in reset.
REQ-032 Reset mid-stall discards the held instruction; the first capture after release behaves as from empty.

Verification
REQ-033 Capture add (rs1=5 holds 7, rs2=6 holds 3, alu_control 0010), out_ready=1 -> next cycle out_valid=1, alu_a=7, alu_b=3, alu_control=0010.
REQ-034 Held rs1=5, exmem_rd=5 with result 0x10, memwb_rd=5 with result 0x20 -> alu_a=0x10; exmem_rd=0 and memwb_rd=0 -> alu_a = held data.
REQ-035 Load-use: exmem_mem_read=1, exmem_rd=rs1=8 -> out_valid=0, in_ready=0; next cycle exmem_mem_read=0 with memwb_rd=8 result 0xAB -> out_valid=1, alu_a=0xAB.
REQ-036 out_ready=0 for 3 cycles while memwb writes rs2=9 with value 0x55 in cycle 1 only -> at release alu_b=0x55 (alu_src=0).
REQ-037 flush with in_valid=1 and valid=1 -> next cycle valid=0; rst_n pulsed low mid-stall -> out_valid=0 immediately and in_ready=1.
REQ-038 Stream of 4 instructions with out_ready=1 -> one fire per cycle, no bubbles, order preserved.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, load-use stall detection,
// EX/MEM and MEM/WB operand forwarding, and write-back snooping of held operands.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rs1_addr,
    input  logic [4:0]  in_rs2_addr,
    input  logic [4:0]  in_rd_addr,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    input  logic [31:0] in_imm,
    input  logic [3:0]  in_alu_control,
    input  logic        in_alu_src,
    input  logic        in_reg_write,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic        flush,
    input  logic        exmem_reg_write,
    input  logic        exmem_mem_read,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_control,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic        out_mem_read,
    output logic        out_mem_write,
    output logic [31:0] store_data
);

    logic        valid_q,       valid_d;
    logic [4:0]  rs1_addr_q,    rs1_addr_d;
    logic [4:0]  rs2_addr_q,    rs2_addr_d;
    logic [4:0]  rd_q,          rd_d;
    logic [31:0] rs1_data_q,    rs1_data_d;
    logic [31:0] rs2_data_q,    rs2_data_d;
    logic [31:0] imm_q,         imm_d;
    logic [3:0]  alu_control_q, alu_control_d;
    logic        alu_src_q,     alu_src_d;
    logic        reg_write_q,   reg_write_d;
    logic        mem_read_q,    mem_read_d;
    logic        mem_write_q,   mem_write_d;

    logic        hazard;
    logic        fire;
    logic        capture;
    logic [31:0] fwd_rs1;
    logic [31:0] fwd_rs2;

    // EX/MEM wins over MEM/WB; a load still in EX/MEM has no result yet.
    function automatic logic [31:0] forward(input logic [4:0] rs, input logic [31:0] held,
                                            input logic ex_rw, input logic ex_mr,
                                            input logic [4:0] ex_rd, input logic [31:0] ex_res,
                                            input logic wb_rw, input logic [4:0] wb_rd,
                                            input logic [31:0] wb_res);
        logic [31:0] r;
        r = held;
        if (rs != 5'd0) begin
            if (ex_rw && (ex_rd == rs) && !ex_mr)
                r = ex_res;
            else if (wb_rw && (wb_rd == rs))
                r = wb_res;
        end
        return r;
    endfunction

    always_comb begin
        hazard = valid_q && exmem_mem_read && exmem_reg_write && (exmem_rd != 5'd0) &&
                 ((exmem_rd == rs1_addr_q) ||
                  ((exmem_rd == rs2_addr_q) && (!alu_src_q || mem_write_q)));
        out_valid = valid_q && !hazard && !flush;
        fire      = out_valid && out_ready;
        in_ready  = !valid_q || fire;
        capture   = in_valid && in_ready;

        fwd_rs1 = forward(rs1_addr_q, rs1_data_q, exmem_reg_write, exmem_mem_read, exmem_rd,
                          exmem_result, memwb_reg_write, memwb_rd, memwb_result);
        fwd_rs2 = forward(rs2_addr_q, rs2_data_q, exmem_reg_write, exmem_mem_read, exmem_rd,
                          exmem_result, memwb_reg_write, memwb_rd, memwb_result);

        alu_a         = fwd_rs1;
        alu_b         = alu_src_q ? imm_q : fwd_rs2;
        store_data    = fwd_rs2;
        alu_control   = alu_control_q;
        out_rd        = rd_q;
        out_reg_write = reg_write_q;
        out_mem_read  = mem_read_q;
        out_mem_write = mem_write_q;
    end

    always_comb begin
        valid_d       = valid_q;
        rs1_addr_d    = rs1_addr_q;
        rs2_addr_d    = rs2_addr_q;
        rd_d          = rd_q;
        rs1_data_d    = rs1_data_q;
        rs2_data_d    = rs2_data_q;
        imm_d         = imm_q;
        alu_control_d = alu_control_q;
        alu_src_d     = alu_src_q;
        reg_write_d   = reg_write_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;

        if (capture) begin
            valid_d       = 1'b1;
            rs1_addr_d    = in_rs1_addr;
            rs2_addr_d    = in_rs2_addr;
            rd_d          = in_rd_addr;
            rs1_data_d    = in_rs1_data;
            rs2_data_d    = in_rs2_data;
            imm_d         = in_imm;
            alu_control_d = in_alu_control;
            alu_src_d     = in_alu_src;
            reg_write_d   = in_reg_write;
            mem_read_d    = in_mem_read;
            mem_write_d   = in_mem_write;
        end else if (fire) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            // Stalled: absorb retiring write-backs so the register file value is not lost.
            if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs1_addr_q))
                rs1_data_d = memwb_result;
            if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs2_addr_q))
                rs2_data_d = memwb_result;
        end

        if (flush)
            valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= 1'b0;
            rs1_addr_q    <= 5'd0;
            rs2_addr_q    <= 5'd0;
            rd_q          <= 5'd0;
            rs1_data_q    <= 32'd0;
            rs2_data_q    <= 32'd0;
            imm_q         <= 32'd0;
            alu_control_q <= 4'd0;
            alu_src_q     <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            rs1_addr_q    <= rs1_addr_d;
            rs2_addr_q    <= rs2_addr_d;
            rd_q          <= rd_d;
            rs1_data_q    <= rs1_data_d;
            rs2_data_q    <= rs2_data_d;
            imm_q         <= imm_d;
            alu_control_q <= alu_control_d;
            alu_src_q     <= alu_src_d;
            reg_write_q   <= reg_write_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
        end
    end

endmodule
